// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 SPI ADC responder: FSM states,
// channel count, command field widths and fixed serial bit levels.
package mcp3008_pkg;

  localparam int ADC_CHANNELS   = 8;
  localparam int CMD_BITS       = 4;   // SGL, D2, D1, D0
  localparam int CH_SEL_BITS    = 3;   // D2, D1, D0
  localparam int DIFF_PAIR_BITS = 2;   // D2, D1 select the input pair

  // Levels driven on dout outside the data word.
  localparam logic SAMPLE_BIT = 1'b0;  // sample period, first driven bit
  localparam logic NULL_BIT   = 1'b0;  // null bit preceding B(n-1)
  localparam logic DONE_BIT   = 1'b0;  // filler after the last data bit

  typedef enum logic [2:0] {
    IDLE, START, CMD, SAMPLE, NULLB, DATA, LSBF, DONE
  } state_t;

endpackage

// File: rtl/mcp3008_responder_spi_in_sync.sv
// spi_in_sync: multi-flop synchronizer for one SPI pin plus rise/fall
// detection in the clk domain. RST_VAL is the pin's idle level so reset
// never fabricates an edge of its own.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Synchronizer chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_prev <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise =  o_sync & ~r_prev;
  assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/mcp3008_responder.sv
// mcp3008_responder: emulates the device side of an MCP3008 SPI ADC.
// Decodes start/SGL/D2..D0 from the master, latches the selected channel
// (single-ended or clamped pseudo-differential) and shifts it back MSB first.
// Optional macro MCP3008_LSB_FIRST_EN: after B0, repeat the word LSB first.
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADC_BITS    = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ad_clk,
  input  logic                             cs,
  input  logic                             din,
  output logic                             dout,
  output logic                             dout_oe,
  input  logic [ADC_CHANNELS*ADC_BITS-1:0] ch_data,
  output logic                             conv_valid,
  output logic [CMD_BITS-1:0]              conv_sel,
  output logic [ADC_BITS-1:0]              conv_value
);

  localparam int                IDX_W    = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(ADC_BITS - 1);
  localparam logic [1:0]        CNT_LAST = 2'(CMD_BITS - 1);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_din_sync, w_din_rise, w_din_fall;
  logic w_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(ad_clk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(cs),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .i_async(din),
    .o_sync(w_din_sync), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  // Only the data level of din and the edges of SCLK are needed.
  assign w_unused = &{w_sclk_sync, w_din_rise, w_din_fall};

  // ---------------------------------------------------------------------
  // Frame arming: after reset the cs synchronizer flushes from its idle
  // level, which would look like a falling edge if cs is held low. Only a
  // falling edge seen after cs was observed high post-flush starts a frame.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES:0] r_flush;
  logic                 r_armed;

  // Track synchronizer flush and arm once cs is seen idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      if (r_flush[SYNC_STAGES] && w_cs_sync) r_armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sample selection, evaluated on the D0 rising edge using the bit that
  // is being shifted in this cycle.
  // ---------------------------------------------------------------------
  logic [CH_SEL_BITS-1:0] r_cmd;
  logic [CMD_BITS-1:0]    w_cmd_next;
  logic [ADC_BITS-1:0]    w_ch [ADC_CHANNELS];
  logic [CH_SEL_BITS-1:0] w_pos, w_neg;
  logic [ADC_BITS:0]      w_diff;
  logic [ADC_BITS-1:0]    w_sample;

  assign w_cmd_next = {r_cmd, w_din_sync};

  for (genvar n = 0; n < ADC_CHANNELS; n++) begin : g_ch
    assign w_ch[n] = ch_data[n*ADC_BITS +: ADC_BITS];
  end

  // Pair {D2,D1} selects channels 2p/2p+1; D0 picks which one is IN+.
  always_comb begin
    w_pos    = {w_cmd_next[DIFF_PAIR_BITS:1],  w_cmd_next[0]};
    w_neg    = {w_cmd_next[DIFF_PAIR_BITS:1], ~w_cmd_next[0]};
    w_diff   = {1'b0, w_ch[w_pos]} - {1'b0, w_ch[w_neg]};
    w_sample = '0;
    if (w_cmd_next[CMD_BITS-1])  w_sample = w_ch[w_cmd_next[CH_SEL_BITS-1:0]];
    else if (!w_diff[ADC_BITS])  w_sample = w_diff[ADC_BITS-1:0];
  end

  // ---------------------------------------------------------------------
  // Frame FSM with registered outputs.
  // ---------------------------------------------------------------------
  state_t              r_state;
  logic                r_dout, r_oe, r_valid;
  logic [CMD_BITS-1:0] r_sel;
  logic [ADC_BITS-1:0] r_value, r_sample;
  logic [1:0]          r_bitcnt;
  logic [IDX_W-1:0]    r_idx;

  // Command decode, latch, and shift-out of the converted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dout   <= 1'b0;
      r_oe     <= 1'b0;
      r_valid  <= 1'b0;
      r_sel    <= '0;
      r_value  <= '0;
      r_sample <= '0;
      r_cmd    <= '0;
      r_bitcnt <= '0;
      r_idx    <= '0;
    end else begin
      r_valid <= 1'b0;
      // cs deasserted aborts any frame; conv outputs are left untouched.
      if (w_cs_rise || (w_cs_sync && r_state != IDLE)) begin
        r_state <= IDLE;
        r_dout  <= 1'b0;
        r_oe    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_dout <= 1'b0;
            r_oe   <= 1'b0;
            if (w_cs_fall && r_armed) r_state <= START;
          end
          START: begin
            // Leading zeros are skipped until the start bit arrives.
            if (w_sclk_rise && w_din_sync) begin
              r_bitcnt <= '0;
              r_state  <= CMD;
            end
          end
          CMD: begin
            if (w_sclk_rise) begin
              r_cmd    <= w_cmd_next[CH_SEL_BITS-1:0];
              r_bitcnt <= r_bitcnt + 2'd1;
              if (r_bitcnt == CNT_LAST) begin
                r_valid  <= 1'b1;
                r_sel    <= w_cmd_next;
                r_value  <= w_sample;
                r_sample <= w_sample;
                r_state  <= SAMPLE;
              end
            end
          end
          SAMPLE: begin
            if (w_sclk_fall) begin
              r_oe    <= 1'b1;
              r_dout  <= SAMPLE_BIT;
              r_state <= NULLB;
            end
          end
          NULLB: begin
            if (w_sclk_fall) begin
              r_dout  <= NULL_BIT;
              r_idx   <= IDX_MSB;
              r_state <= DATA;
            end
          end
          DATA: begin
            if (w_sclk_fall) begin
              r_dout <= r_sample[r_idx];
              if (r_idx == '0) begin
`ifdef MCP3008_LSB_FIRST_EN
                r_idx   <= IDX_W'(1);
                r_state <= LSBF;
`else
                r_state <= DONE;
`endif
              end else begin
                r_idx <= r_idx - IDX_W'(1);
              end
            end
          end
`ifdef MCP3008_LSB_FIRST_EN
          LSBF: begin
            // B0 was already sent; continue with B1 upward.
            if (w_sclk_fall) begin
              r_dout <= r_sample[r_idx];
              if (r_idx == IDX_MSB) r_state <= DONE;
              else                  r_idx   <= r_idx + IDX_W'(1);
            end
          end
`endif
          DONE: begin
            r_oe <= 1'b1;
            if (w_sclk_fall) r_dout <= DONE_BIT;
          end
          default: begin
            r_state <= IDLE;
            r_dout  <= 1'b0;
            r_oe    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_oe    = r_oe;
  assign conv_valid = r_valid;
  assign conv_sel   = r_sel;
  assign conv_value = r_value;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: vector table of frames, directed abort and
// reset sequences, then random frames against a behavioural ADC model.
module tb_mcp3008_responder;

  localparam int SYNC = 2;
  localparam int AB   = 10;
  localparam int NCH  = 8;
  localparam int HALF = 8;   // SCLK half period in clk cycles

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ad_clk = 1'b0;
  logic              cs = 1'b1;
  logic              din = 1'b0;
  logic              dout, dout_oe;
  logic [NCH*AB-1:0] ch_data;
  logic              conv_valid;
  logic [3:0]        conv_sel;
  logic [AB-1:0]     conv_value;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;

  always #5 clk = ~clk;

  // Count clk cycles with conv_valid high (one per frame if it pulses once).
  always @(negedge clk) if (conv_valid) n_valid++;

  mcp3008_responder #(.SYNC_STAGES(SYNC), .ADC_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din),
    .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
    .conv_valid(conv_valid), .conv_sel(conv_sel), .conv_value(conv_value)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural ADC model straight from the channel-select rules.
  function automatic int chv(input logic [NCH*AB-1:0] cd, input int n);
    return int'(cd[n*AB +: AB]);
  endfunction

  function automatic int model(input logic [NCH*AB-1:0] cd, input logic [3:0] c);
    int p, inp, inm;
    if (c[3]) return chv(cd, int'(c[2:0]));
    p = int'(c[2:1]);
    if (!c[0]) begin inp = chv(cd, 2*p);   inm = chv(cd, 2*p+1); end
    else       begin inp = chv(cd, 2*p+1); inm = chv(cd, 2*p);   end
    return (inp > inm) ? inp - inm : 0;
  endfunction

  // One SCLK period, mode 0: din set while low, dout captured at the rise.
  task automatic sclk(input logic b, output logic d, output logic oe);
    din = b;
    repeat (HALF) @(negedge clk);
    d = dout; oe = dout_oe;
    ad_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ad_clk = 1'b0;
  endtask

  // Full frame: 'lead' zeros, start bit, 4 command bits, random filler.
  task automatic frame(input string tag, input int lead, input logic [3:0] c,
                       input int nclk, input bit scramble, input logic [AB-1:0] exp_v);
    logic [63:0] rd, oe, tail, etail;
    logic [AB-1:0] word;
    logic d, o;
    int base;
    rd = '0; oe = '0; tail = '0; etail = '0;
    base = n_valid;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nclk; k++) begin
      logic b;
      if (k < lead)           b = 1'b0;
      else if (k == lead)     b = 1'b1;
      else if (k <= lead + 4) b = c[3 - (k - lead - 1)];
      else                    b = 1'($urandom_range(0, 1));
      sclk(b, d, o);
      rd[k] = d; oe[k] = o;
      if (scramble && k == lead + 5) ch_data = 80'({$urandom, $urandom, $urandom});
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1; din = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int j = 0; j < AB; j++) word[AB-1-j] = rd[lead + 7 + j];
    for (int k = lead + 17; k < nclk; k++) begin
      int j;
      j = k - lead - 7;
      tail[k] = rd[k];
`ifdef MCP3008_LSB_FIRST_EN
      if (j <= 2*AB - 2) etail[k] = exp_v[j - (AB - 1)];
`endif
    end
    check({tag, " valid_pulses"}, 64'(n_valid - base), 64'd1);
    check({tag, " conv_sel"},   conv_sel,   c);
    check({tag, " conv_value"}, conv_value, exp_v);
    check({tag, " oe_start"},   {oe[lead+4], oe[lead+5]}, 2'b01);
    check({tag, " null_bit"},   rd[lead+6], 1'b0);
    check({tag, " data_word"},  word, exp_v);
    check({tag, " tail_bits"},  tail, etail);
    check({tag, " oe_after_cs"}, {dout_oe, dout}, 2'b00);
  endtask

  typedef struct {
    int            lead;
    logic [3:0]    cmd;
    int            nclk;
    logic [AB-1:0] exp_v;
  } vec_t;

  vec_t tbl [8];
  logic [AB-1:0] base_ch [NCH];

  initial begin
    logic d, o, oe_seen;
    logic [3:0] got4;
    logic [NCH*AB-1:0] cd;
    logic [3:0] c;
    int lead, cnt, t;

    base_ch = '{10'h3FF, 10'd0, 10'd700, 10'd300, 10'd100, 10'h2A5, 10'd1, 10'd2};
    for (int n = 0; n < NCH; n++) ch_data[n*AB +: AB] = base_ch[n];

    tbl[0] = '{0, 4'b1101, 24, 10'h2A5};  // single-ended ch5
    tbl[1] = '{0, 4'b0010, 24, 10'd400};  // ch2 - ch3
    tbl[2] = '{0, 4'b0011, 24, 10'd0};    // ch3 - ch2, clamped
    tbl[3] = '{7, 4'b1101, 24, 10'h2A5};  // 8-clock/byte framing
    tbl[4] = '{0, 4'b1000, 24, 10'h3FF};  // full scale ch0
    tbl[5] = '{3, 4'b0101, 26, 10'd577};  // ch5 - ch4
    tbl[6] = '{0, 4'b0100, 24, 10'd0};    // ch4 - ch5, clamped
    tbl[7] = '{0, 4'b1101, 28, 10'h2A5};  // 28 SCLKs, tail after B0

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {dout, dout_oe, conv_valid, conv_sel, conv_value}, '0);
    rst_n = 1'b1;
    repeat (2*HALF) @(negedge clk);

    for (int i = 0; i < 8; i++)
      frame($sformatf("vec%0d", i), tbl[i].lead, tbl[i].cmd, tbl[i].nclk, 1'b0, tbl[i].exp_v);

    // Abort mid-DATA after four data bits.
    cnt = n_valid;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk(1'b1, d, o); sclk(1'b1, d, o); sclk(1'b1, d, o);
    sclk(1'b0, d, o); sclk(1'b1, d, o); sclk(1'b0, d, o); sclk(1'b0, d, o);
    for (int j = 0; j < 4; j++) begin sclk(1'b0, d, o); got4[3-j] = d; end
    check("abort first_bits", got4, 4'b1010);
    repeat (HALF/2) @(negedge clk);
    cs = 1'b1;
    t = 0;
    while (dout_oe && t < SYNC + 2) begin @(negedge clk); t++; end
    check("abort oe_dropped", {dout_oe, dout}, 2'b00);
    check("abort conv_kept", {conv_sel, conv_value}, {4'b1101, 10'h2A5});
    check("abort valid_pulses", 64'(n_valid - cnt), 64'd1);
    repeat (2*HALF) @(negedge clk);
    frame("post_abort", 0, 4'b0010, 24, 1'b0, 10'd400);

    // Reset mid-frame, release with cs still low, then a clean frame.
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    sclk(1'b1, d, o); sclk(1'b1, d, o); sclk(1'b0, d, o);
    sclk(1'b0, d, o); sclk(1'b0, d, o);
    for (int j = 0; j < 5; j++) sclk(1'b0, d, o);
    rst_n = 1'b0;
    #1;
    check("midframe_reset", {dout, dout_oe, conv_valid, conv_sel, conv_value}, '0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    cnt = n_valid; oe_seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      sclk((k % 3) != 2, d, o);
      oe_seen |= o;
    end
    check("cs_low_at_release valid", 64'(n_valid - cnt), 64'd0);
    check("cs_low_at_release oe", {oe_seen, dout_oe}, 2'b00);
    cs = 1'b1;
    repeat (2*HALF) @(negedge clk);
    frame("post_reset", 0, 4'b1101, 24, 1'b0, 10'h2A5);

    // Random frames; ch_data is scrambled after the latch point.
    for (int i = 0; i < 10; i++) begin
      cd = 80'({$urandom, $urandom, $urandom});
      ch_data = cd;
      c = 4'($urandom);
      lead = $urandom_range(0, 7);
      frame($sformatf("rand%0d", i), lead, c, lead + 17 + $urandom_range(0, 11),
            1'b1, AB'(model(cd, c)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
